// File: rtl/bpu_gshare_btb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bpu_gshare_btb
//
// ID-stage branch predictor.
//   * Conditional branches: gshare PHT of 2-bit saturating counters, indexed
//     by PC[PHT_IDX_W+1:2] xor the zero-extended global history register.
//   * J/JAL: target computed from the instruction, always predicted taken.
//   * JR/JALR: target from a direct-mapped BTB (valid + tag + target).
// The prediction is combinational in the same cycle as ID. Training arrives
// from MEM: PHT counter updates, BTB writes, and GHR repair on a mispredict.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset.
//                      resetn is expected to be released synchronously to
//                      clk by an upstream reset synchroniser.
//   id_valid           ID instruction is real and advances this cycle
//   id_instr/id_pc     ID instruction word and its PC
//   id_pc_4            id_pc + 4
//   bp_result          predict taken / redirect
//   bp_addr            predicted target (0 when not taken)
//   bp_ghr             history used for this lookup; travels with the instr
//   mem_pc_branch      MEM holds a resolved conditional branch (PHT update)
//   mem_jr             MEM holds a resolved JR/JALR (BTB write)
//   mem_pc             PC of the MEM instruction
//   mem_branch_state   resolved direction (1 = taken)
//   mem_target         resolved JR/JALR target
//   mem_ghr            bp_ghr value that travelled with the MEM instruction
//   mem_mispredict     MEM detected a mispredict; the pipeline flushes
//
// GHR_W = 0 turns the PHT into a plain bimodal table; the history ports are
// then one bit wide, bp_ghr reads 0 and mem_ghr is ignored.
// -----------------------------------------------------------------------------
module bpu_gshare_btb #(
    parameter int         PHT_IDX_W = 8,
    parameter int         GHR_W     = 8,
    parameter int         BTB_IDX_W = 5,
    parameter int         BTB_TAG_W = 10,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 id_valid,
    input  logic [31:0]                          id_instr,
    input  logic [31:0]                          id_pc,
    input  logic [31:0]                          id_pc_4,
    output logic                                 bp_result,
    output logic [31:0]                          bp_addr,
    output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] bp_ghr,
    input  logic                                 mem_pc_branch,
    input  logic                                 mem_jr,
    input  logic [31:0]                          mem_pc,
    input  logic                                 mem_branch_state,
    input  logic [31:0]                          mem_target,
    input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0] mem_ghr,
    input  logic                                 mem_mispredict
);

    localparam int GW     = (GHR_W > 0) ? GHR_W : 1;
    localparam int PHT_N  = 1 << PHT_IDX_W;
    localparam int BTB_N  = 1 << BTB_IDX_W;
    localparam int TAG_LO = BTB_IDX_W + 2;
    localparam int TAG_HI = TAG_LO + BTB_TAG_W - 1;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] func;
    logic       is_cond;
    logic       is_jmp;
    logic       is_ind;

    assign opcode = id_instr[31:26];
    assign rt     = id_instr[20:16];
    assign func   = id_instr[5:0];

    always_comb begin
        is_cond = 1'b0;
        is_jmp  = 1'b0;
        is_ind  = 1'b0;
        case (opcode)
            6'b000100, 6'b000101, 6'b000110, 6'b000111: is_cond = 1'b1;
            // REGIMM: only BLTZ/BGEZ/BLTZAL/BGEZAL are branches
            6'b000001: is_cond = (rt == 5'b00000) || (rt == 5'b00001) ||
                                 (rt == 5'b10000) || (rt == 5'b10001);
            6'b000010, 6'b000011: is_jmp = 1'b1;
            6'b000000: is_ind = (func == 6'b001000) || (func == 6'b001001);
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Global history
    // ------------------------------------------------------------------
    logic [GW-1:0]        ghr_reg;
    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [PHT_IDX_W-1:0] mem_ghr_ext;
    logic                 pred_taken;

    function automatic logic [GW-1:0] hist_shift(input logic [GW-1:0] h,
                                                 input logic          b);
        logic [GW:0] t;
        t = {h, b};
        return t[GW-1:0];
    endfunction

    generate
        if (GHR_W > 0) begin : g_hist
            logic [GW-1:0] ghr_next;

            always_comb begin
                ghr_ext              = '0;
                mem_ghr_ext          = '0;
                ghr_ext[GW-1:0]      = ghr_reg;
                mem_ghr_ext[GW-1:0]  = mem_ghr;
            end

            // Recovery outranks the speculative ID shift: the ID
            // instruction is being flushed in the same cycle.
            always_comb begin
                ghr_next = ghr_reg;
                if (mem_mispredict && mem_pc_branch)
                    ghr_next = hist_shift(mem_ghr, mem_branch_state);
                else if (mem_mispredict)
                    ghr_next = mem_ghr;
                else if (id_valid && is_cond)
                    ghr_next = hist_shift(ghr_reg, pred_taken);
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    ghr_reg <= '0;
                else
                    ghr_reg <= ghr_next;
            end
        end else begin : g_no_hist
            assign ghr_ext     = '0;
            assign mem_ghr_ext = '0;
            assign ghr_reg     = '0;
        end
    endgenerate

    assign bp_ghr = ghr_reg;

    // ------------------------------------------------------------------
    // Pattern history table
    // ------------------------------------------------------------------
    logic [PHT_IDX_W-1:0] pidx;
    logic [PHT_IDX_W-1:0] uidx;
    logic [1:0]           pht [PHT_N];
    logic [1:0]           upd_ctr;
    logic [1:0]           upd_next;

    assign pidx    = id_pc[PHT_IDX_W+1:2] ^ ghr_ext;
    assign uidx    = mem_pc[PHT_IDX_W+1:2] ^ mem_ghr_ext;
    assign upd_ctr = pht[uidx];

    always_comb begin
        upd_next = upd_ctr;
        if (mem_branch_state) begin
            if (upd_ctr != 2'b11)
                upd_next = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00)
                upd_next = upd_ctr - 2'b01;
        end
    end

    // Counters are individual flops so that reset can restore every entry
    // to CTR_INIT at once; reads are combinational for the 0-cycle lookup.
    generate
        for (genvar gi = 0; gi < PHT_N; gi++) begin : g_pht
            logic [1:0] ctr_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    ctr_reg <= CTR_INIT;
                else if (mem_pc_branch && (uidx == PHT_IDX_W'(gi)))
                    ctr_reg <= upd_next;
            end

            assign pht[gi] = ctr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Branch target buffer
    // ------------------------------------------------------------------
    logic                  btb_valid  [BTB_N];
    logic [BTB_TAG_W-1:0]  btb_tag    [BTB_N];
    logic [31:0]           btb_target [BTB_N];
    logic                  btb_we;
    logic [BTB_IDX_W-1:0]  widx;
    logic [BTB_TAG_W-1:0]  wtag;
    logic [BTB_IDX_W-1:0]  ridx;
    logic [BTB_TAG_W-1:0]  rtag;
    logic                  btb_hit;

    // A simultaneous conditional-branch update takes precedence.
    assign btb_we = mem_jr && !mem_pc_branch;
    assign widx   = mem_pc[BTB_IDX_W+1:2];
    assign wtag   = mem_pc[TAG_HI:TAG_LO];
    assign ridx   = id_pc[BTB_IDX_W+1:2];
    assign rtag   = id_pc[TAG_HI:TAG_LO];

    generate
        for (genvar gi = 0; gi < BTB_N; gi++) begin : g_btb_valid
            logic valid_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    valid_reg <= 1'b0;
                else if (btb_we && (widx == BTB_IDX_W'(gi)))
                    valid_reg <= 1'b1;
            end

            assign btb_valid[gi] = valid_reg;
        end
    endgenerate

    // Tag/target need no reset: a write that lands while resetn is low is
    // invisible because the matching valid bit is held clear.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag[widx]    <= wtag;
            btb_target[widx] <= mem_target;
        end
    end

    assign btb_hit = btb_valid[ridx] && (btb_tag[ridx] == rtag);

    // ------------------------------------------------------------------
    // Prediction
    // ------------------------------------------------------------------
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] pred_addr;

    assign br_target = id_pc_4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign j_target  = {id_pc_4[31:28], id_instr[25:0], 2'b00};

    // pred_taken excludes resetn so the reset net only gates the output;
    // the history register is held in reset anyway while resetn is low.
    always_comb begin
        pred_taken = 1'b0;
        pred_addr  = 32'h0;
        if (id_valid) begin
            if (is_cond) begin
                if (pht[pidx][1]) begin
                    pred_taken = 1'b1;
                    pred_addr  = br_target;
                end
            end else if (is_jmp) begin
                pred_taken = 1'b1;
                pred_addr  = j_target;
            end else if (is_ind && btb_hit) begin
                pred_taken = 1'b1;
                pred_addr  = btb_target[ridx];
            end
        end
    end

    assign bp_result = pred_taken && resetn;
    assign bp_addr   = resetn ? pred_addr : 32'h0;

    // PC/history bits outside the index/tag fields are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{id_pc, mem_pc, mem_ghr};

endmodule

// File: tb/tb_bpu_gshare_btb.sv
`timescale 1ns/1ps
module tb_bpu_gshare_btb;

    localparam logic [31:0] BEQ_I    = 32'h1000_0004;
    localparam logic [31:0] J_I      = 32'h0800_0100;
    localparam logic [31:0] JR_I     = 32'h03E0_0008;
    localparam logic [31:0] JALR_I   = 32'h03E0_F809;
    localparam logic [31:0] BLTZAL_I = 32'h0410_FFFF;
    localparam logic [31:0] ADD_I    = 32'h0000_0020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default gshare build
    logic        resetn, id_valid, bp_result;
    logic [31:0] id_instr, id_pc, id_pc_4, bp_addr;
    logic [7:0]  bp_ghr, mem_ghr;
    logic        mem_pc_branch, mem_jr, mem_branch_state, mem_mispredict;
    logic [31:0] mem_pc, mem_target;

    // Instance B: GHR_W = 0 (bimodal) build
    logic        b_resetn, b_id_valid, b_bp_result;
    logic [31:0] b_id_instr, b_id_pc, b_id_pc_4, b_bp_addr;
    logic [0:0]  b_bp_ghr, b_mem_ghr;
    logic        b_mem_pc_branch, b_mem_jr, b_mem_branch_state, b_mem_mispredict;
    logic [31:0] b_mem_pc, b_mem_target;

    int n_checks = 0;
    int n_fail   = 0;

    bpu_gshare_btb dut_a (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_4(id_pc_4), .bp_result(bp_result), .bp_addr(bp_addr),
        .bp_ghr(bp_ghr), .mem_pc_branch(mem_pc_branch), .mem_jr(mem_jr),
        .mem_pc(mem_pc), .mem_branch_state(mem_branch_state), .mem_target(mem_target),
        .mem_ghr(mem_ghr), .mem_mispredict(mem_mispredict)
    );

    bpu_gshare_btb #(.GHR_W(0)) dut_b (
        .clk(clk), .resetn(b_resetn), .id_valid(b_id_valid), .id_instr(b_id_instr),
        .id_pc(b_id_pc), .id_pc_4(b_id_pc_4), .bp_result(b_bp_result), .bp_addr(b_bp_addr),
        .bp_ghr(b_bp_ghr), .mem_pc_branch(b_mem_pc_branch), .mem_jr(b_mem_jr),
        .mem_pc(b_mem_pc), .mem_branch_state(b_mem_branch_state), .mem_target(b_mem_target),
        .mem_ghr(b_mem_ghr), .mem_mispredict(b_mem_mispredict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID of instance A and let outputs settle.
    task automatic lookup(input logic [31:0] instr, input logic [31:0] pc);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
        id_pc_4  = pc + 32'd4;
        #1;
    endtask

    task automatic b_lookup(input logic [31:0] instr, input logic [31:0] pc);
        b_id_valid = 1'b1;
        b_id_instr = instr;
        b_id_pc    = pc;
        b_id_pc_4  = pc + 32'd4;
        #1;
    endtask

    // One-cycle conditional-branch training on instance A.
    task automatic mem_br(input logic [31:0] pc, input logic [7:0] g, input logic st);
        mem_pc_branch    = 1'b1;
        mem_pc           = pc;
        mem_ghr          = g;
        mem_branch_state = st;
        tick();
        mem_pc_branch    = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc = '0; id_pc_4 = '0;
        mem_pc_branch = 1'b0; mem_jr = 1'b0; mem_pc = '0; mem_branch_state = 1'b0;
        mem_target = '0; mem_ghr = '0; mem_mispredict = 1'b0;
        b_resetn = 1'b0; b_id_valid = 1'b0; b_id_instr = '0; b_id_pc = '0; b_id_pc_4 = '0;
        b_mem_pc_branch = 1'b0; b_mem_jr = 1'b0; b_mem_pc = '0; b_mem_branch_state = 1'b0;
        b_mem_target = '0; b_mem_ghr = '0; b_mem_mispredict = 1'b0;

        // Reset: a J in ID must not predict while resetn is low
        #2;
        lookup(J_I, 32'hBFC0_0000);
        chk("rst_gate", {31'b0, bp_result}, 32'h0);
        chk("rst_ghr", {24'b0, bp_ghr}, 32'h0);
        id_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        b_resetn = 1'b1;

        // T1: fresh counter (01) -> not taken; same-cycle update not bypassed
        mem_pc_branch = 1'b1; mem_pc = 32'h8000_0040; mem_ghr = 8'h00; mem_branch_state = 1'b1;
        lookup(BEQ_I, 32'h8000_0040);
        chk("t1_result", {31'b0, bp_result}, 32'h0);
        chk("t1_ghr", {24'b0, bp_ghr}, 32'h0);
        tick();                                   // counter 01->10, ghr shifts in 0
        lookup(BEQ_I, 32'h8000_0040);
        chk("t2_visible", {31'b0, bp_result}, 32'h1);
        chk("t2_addr", bp_addr, 32'h8000_0054);
        id_valid = 1'b0;
        tick(); tick(); tick();                   // 10->11->11->11
        mem_pc_branch = 1'b0;
        lookup(BEQ_I, 32'h8000_0040);
        chk("t2_sat", {31'b0, bp_result}, 32'h1);
        chk("t2_sat_addr", bp_addr, 32'h8000_0054);
        id_valid = 1'b0;
        mem_br(32'h8000_0040, 8'h00, 1'b0);       // 11->10
        lookup(BEQ_I, 32'h8000_0040);
        chk("t2_dec1", {31'b0, bp_result}, 32'h1);
        id_valid = 1'b0;
        mem_br(32'h8000_0040, 8'h00, 1'b0);       // 10->01
        lookup(BEQ_I, 32'h8000_0040);
        chk("t2_dec2", {31'b0, bp_result}, 32'h0);
        chk("t2_nt_addr", bp_addr, 32'h0);
        id_valid = 1'b0;
        repeat (3) mem_br(32'h8000_0040, 8'h00, 1'b0);  // 01->00->00->00
        repeat (2) mem_br(32'h8000_0040, 8'h00, 1'b1);  // 00->01->10
        lookup(BEQ_I, 32'h8000_0040);
        chk("t2_floor", {31'b0, bp_result}, 32'h1);

        // Speculative shifts: taken (ghr 0->1), then index moves to 0x11 (not taken)
        tick();
        chk("ghr_shift1", {24'b0, bp_ghr}, 32'h01);
        chk("ghr_index", {31'b0, bp_result}, 32'h0);
        tick();
        id_valid = 1'b0;
        chk("ghr_shift0", {24'b0, bp_ghr}, 32'h02);

        // T4: taken prediction (0x12^0x02 -> counter 0x10) races a recovery
        mem_mispredict = 1'b1; mem_pc_branch = 1'b1; mem_pc = 32'h8000_0100;
        mem_ghr = 8'h05; mem_branch_state = 1'b0;
        lookup(BEQ_I, 32'h8000_0048);
        chk("t4_pred", {31'b0, bp_result}, 32'h1);
        chk("t4_addr", bp_addr, 32'h8000_005C);
        tick();
        mem_mispredict = 1'b0; mem_pc_branch = 1'b0; id_valid = 1'b0;
        #1;
        chk("t4_recover", {24'b0, bp_ghr}, 32'h0A);

        // Mispredict without a branch update restores mem_ghr verbatim
        mem_mispredict = 1'b1; mem_ghr = 8'h33;
        lookup(BEQ_I, 32'h8000_0040);
        tick();
        mem_mispredict = 1'b0; id_valid = 1'b0;
        #1;
        chk("t4_mp_only", {24'b0, bp_ghr}, 32'h33);

        // T3: BTB miss, write, hit; JALR shares the entry; alias misses
        mem_jr = 1'b1; mem_pc = 32'h8000_1000; mem_target = 32'h8000_2000;
        lookup(JR_I, 32'h8000_1000);
        chk("t3_miss", {31'b0, bp_result}, 32'h0);
        chk("t3_miss_addr", bp_addr, 32'h0);
        tick();
        mem_jr = 1'b0;
        #1;
        chk("t3_hit", {31'b0, bp_result}, 32'h1);
        chk("t3_target", bp_addr, 32'h8000_2000);
        lookup(JALR_I, 32'h8000_1000);
        chk("t3_jalr", {31'b0, bp_result}, 32'h1);
        lookup(JR_I, 32'h8000_3000);
        chk("t3_alias", {31'b0, bp_result}, 32'h0);
        id_valid = 1'b0;

        // mem_jr together with mem_pc_branch: BTB write dropped
        mem_jr = 1'b1; mem_pc_branch = 1'b1; mem_pc = 32'h8000_1004;
        mem_target = 32'h8000_4000; mem_ghr = 8'h00; mem_branch_state = 1'b0;
        tick();
        mem_jr = 1'b0; mem_pc_branch = 1'b0;
        lookup(JR_I, 32'h8000_1004);
        chk("t3_drop", {31'b0, bp_result}, 32'h0);
        id_valid = 1'b0;

        // Unconditional overwrite of an existing entry
        mem_jr = 1'b1; mem_pc = 32'h8000_1000; mem_target = 32'h8000_5000;
        tick();
        mem_jr = 1'b0;
        lookup(JR_I, 32'h8000_1000);
        chk("t3_overwrite", bp_addr, 32'h8000_5000);
        id_valid = 1'b0;

        // REGIMM BLTZAL with a negative offset, trained under ghr 0x33
        repeat (2) mem_br(32'h8000_0200, 8'h33, 1'b1);
        lookup(BLTZAL_I, 32'h8000_0200);
        chk("bltzal_res", {31'b0, bp_result}, 32'h1);
        chk("bltzal_addr", bp_addr, 32'h8000_0200);
        chk("bltzal_ghr", {24'b0, bp_ghr}, 32'h33);
        lookup(ADD_I, 32'h8000_0200);
        chk("alu_res", {31'b0, bp_result}, 32'h0);
        chk("alu_addr", bp_addr, 32'h0);

        // T5: J target computed; jumps do not touch history
        lookup(J_I, 32'hBFC0_0000);
        chk("t5_res", {31'b0, bp_result}, 32'h1);
        chk("t5_addr", bp_addr, 32'hB000_0400);
        tick();
        chk("t5_ghr", {24'b0, bp_ghr}, 32'h33);
        id_valid = 1'b0;
        #1;
        chk("idv_gate", {31'b0, bp_result}, 32'h0);

        // T6: bimodal build; history input ignored
        b_mem_pc_branch = 1'b1; b_mem_pc = 32'h8000_0040; b_mem_ghr = 1'b1; b_mem_branch_state = 1'b1;
        tick();
        b_mem_pc_branch = 1'b0;
        b_lookup(BEQ_I, 32'h8000_0040);
        chk("t6_bimodal", {31'b0, b_bp_result}, 32'h1);
        chk("t6_ghr", {31'b0, b_bp_ghr}, 32'h0);
        // Reset asserted while an update is on the port
        b_mem_pc_branch = 1'b1; b_mem_pc = 32'h8000_0080; b_mem_branch_state = 1'b1;
        #2;
        b_resetn = 1'b0;
        #1;
        chk("t6_rst_gate", {31'b0, b_bp_result}, 32'h0);
        tick();
        b_mem_pc_branch = 1'b0;
        b_resetn = 1'b1;
        b_lookup(BEQ_I, 32'h8000_0080);
        chk("t6_abort", {31'b0, b_bp_result}, 32'h0);
        b_lookup(BEQ_I, 32'h8000_0040);
        chk("t6_cleared", {31'b0, b_bp_result}, 32'h0);
        b_id_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
